// File: rtl/bram_dbg_pkg.sv
// Shared types and constants for the BRAM debug load/dump sequencer.
package bram_dbg_pkg;

    typedef enum logic {
        OP_LOAD = 1'b0,
        OP_DUMP = 1'b1
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DUMP_RD,
        ST_DUMP_OUT,
        ST_VERIFY,
        ST_HOLD
    } state_e;

    localparam int DATA_W_DEF     = 32;
    localparam int BYTES_PER_WORD = DATA_W_DEF / 8;
    // Word index to byte address: idx * 4.
    localparam int WORD_SHIFT     = 2;

endpackage

// File: rtl/bram_dbg_chan_mux.sv
// Routes the sequencer's single BRAM access onto the selected debug channel and
// returns that channel's read data. Unselected channels see all-zero a2/wd2/we2.
module bram_dbg_chan_mux
    import bram_dbg_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int CHAN_W   = 2,
    parameter int BE_W     = BYTES_PER_WORD
) (
    input  logic [CHAN_W-1:0]          sel,
    input  logic [ADDR_W-1:0]          a2,
    input  logic [DATA_W-1:0]          wd2,
    input  logic                       we,
    output logic [CHANNELS*ADDR_W-1:0] dbg_a2,
    output logic [CHANNELS*DATA_W-1:0] dbg_wd2,
    output logic [CHANNELS*BE_W-1:0]   dbg_we2,
    input  logic [CHANNELS*DATA_W-1:0] dbg_rd2,
    output logic [DATA_W-1:0]          rd_sel
);

    // Demux the access onto one channel, mux that channel's read data back.
    always_comb begin
        dbg_a2  = '0;
        dbg_wd2 = '0;
        dbg_we2 = '0;
        rd_sel  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (sel == CHAN_W'(c)) begin
                dbg_a2[c*ADDR_W +: ADDR_W] = a2;
                dbg_wd2[c*DATA_W +: DATA_W] = wd2;
                dbg_we2[c*BE_W +: BE_W]     = {BE_W{we}};
                rd_sel                      = dbg_rd2[c*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/bram_debug_sequencer.sv
// Load/dump engine for the RV32I core's BRAM debug ports. Holds the core in
// reset while streaming words in (load) or out (dump), then releases it after
// RST_HOLD cycles.
// Optional build macro: BRAM_LOAD_VERIFY_EN adds a read-back checksum pass
// after every load and the verify_err output.
//
// state       | meaning
// ST_IDLE     | waiting for a command, cmd_ready high
// ST_LOAD     | accepting in_* beats, one BRAM write per beat
// ST_DUMP_RD  | address presented to BRAM, data arrives next cycle
// ST_DUMP_OUT | word offered on out_*, held until out_ready
// ST_VERIFY   | re-reading loaded words and folding them into a checksum
// ST_HOLD     | op finished, core_rst held for RST_HOLD cycles
module bram_debug_sequencer
    import bram_dbg_pkg::*;
#(
    parameter int  CHANNELS = 2,
    parameter int  WORDS    = 4096,
    parameter int  DATA_W   = 32,
    parameter int  ADDR_W   = 32,
    parameter int  RST_HOLD = 4,
    // One spare code point so an out-of-range channel can be presented and flagged.
    localparam int CHAN_W   = $clog2(CHANNELS + 1),
    localparam int LEN_W    = $clog2(WORDS) + 1,
    localparam int BE_W     = DATA_W / 8
) (
    input  logic                       CPU_CLK,
    input  logic                       CPU_RST,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_op,
    input  logic [CHAN_W-1:0]          cmd_chan,
    input  logic [LEN_W-1:0]           cmd_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ADDR_W-1:0]          out_addr,
    output logic                       out_last,
    output logic [CHANNELS*ADDR_W-1:0] dbg_a2,
    output logic [CHANNELS*DATA_W-1:0] dbg_wd2,
    output logic [CHANNELS*BE_W-1:0]   dbg_we2,
    input  logic [CHANNELS*DATA_W-1:0] dbg_rd2,
    output logic                       core_rst,
    output logic                       busy,
    output logic                       done,
    output logic                       cmd_err,
    output logic [LEN_W-1:0]           words_done
`ifdef BRAM_LOAD_VERIFY_EN
    ,
    output logic                       verify_err
`endif
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    idx_q, idx_d, len_q, len_d, words_done_q, words_done_d;
    logic [LEN_W-1:0]    len_eff, idx_inc;
    logic [CHAN_W-1:0]   chan_q, chan_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                core_rst_q, core_rst_d, done_q, done_d, cmd_err_q, cmd_err_d;
    logic                first_q, first_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d, rd_sel, bram_wd;
    logic [ADDR_W-1:0]   idx_addr, bram_a2;
    logic                bram_we;
`ifdef BRAM_LOAD_VERIFY_EN
    logic [DATA_W-1:0]   shadow_q, shadow_d, vacc_q, vacc_d;
    logic [LEN_W-1:0]    vcnt_q, vcnt_d;
    logic                pend_q, pend_d, verify_err_q, verify_err_d;
`endif

    assign len_eff  = (cmd_len > LEN_W'(WORDS)) ? LEN_W'(WORDS) : cmd_len;
    assign idx_inc  = idx_q + LEN_W'(1);
    assign idx_addr = ADDR_W'(idx_q) << WORD_SHIFT;

    bram_dbg_chan_mux #(
        .CHANNELS (CHANNELS),
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .CHAN_W   (CHAN_W),
        .BE_W     (BE_W)
    ) u_mux (
        .sel     (chan_q),
        .a2      (bram_a2),
        .wd2     (bram_wd),
        .we      (bram_we),
        .dbg_a2  (dbg_a2),
        .dbg_wd2 (dbg_wd2),
        .dbg_we2 (dbg_we2),
        .dbg_rd2 (dbg_rd2),
        .rd_sel  (rd_sel)
    );

    // Next-state, stream handshakes and the BRAM access for this cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        len_d        = len_q;
        chan_d       = chan_q;
        hold_d       = hold_q;
        core_rst_d   = core_rst_q;
        words_done_d = words_done_q;
        out_data_d   = out_data_q;
        done_d       = 1'b0;
        cmd_err_d    = 1'b0;
        first_d      = 1'b0;
        bram_a2      = '0;
        bram_wd      = '0;
        bram_we      = 1'b0;
        cmd_ready    = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_addr     = '0;
        out_data     = out_data_q;
`ifdef BRAM_LOAD_VERIFY_EN
        shadow_d     = shadow_q;
        vacc_d       = vacc_q;
        vcnt_d       = vcnt_q;
        pend_d       = 1'b0;
        verify_err_d = verify_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
`ifdef BRAM_LOAD_VERIFY_EN
                    verify_err_d = 1'b0;
                    shadow_d     = '0;
                    vacc_d       = '0;
                    vcnt_d       = '0;
`endif
                    if (cmd_chan >= CHAN_W'(CHANNELS)) begin
                        cmd_err_d = 1'b1;
                    end else if (len_eff == '0) begin
                        done_d       = 1'b1;
                        words_done_d = '0;
                    end else begin
                        chan_d     = cmd_chan;
                        len_d      = len_eff;
                        idx_d      = '0;
                        core_rst_d = 1'b1;
                        state_d    = (op_e'(cmd_op) == OP_DUMP) ? ST_DUMP_RD : ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    bram_a2 = idx_addr;
                    bram_wd = in_data;
                    bram_we = 1'b1;
                    idx_d   = idx_inc;
`ifdef BRAM_LOAD_VERIFY_EN
                    shadow_d = shadow_q ^ in_data;
`endif
                    if (idx_inc == len_q || in_last) begin
                        words_done_d = idx_inc;
                        idx_d        = '0;
`ifdef BRAM_LOAD_VERIFY_EN
                        state_d = ST_VERIFY;
`else
                        done_d  = 1'b1;
                        hold_d  = HOLD_W'(RST_HOLD - 1);
                        state_d = ST_HOLD;
`endif
                    end
                end
            end
            ST_DUMP_RD: begin
                bram_a2 = idx_addr;
                first_d = 1'b1;
                state_d = ST_DUMP_OUT;
            end
            ST_DUMP_OUT: begin
                // Registered BRAM data is live only on the first cycle; capture it for stalls.
                out_valid  = 1'b1;
                out_addr   = idx_addr;
                out_last   = (idx_inc == len_q);
                out_data   = first_q ? rd_sel : out_data_q;
                out_data_d = out_data;
                if (out_ready) begin
                    if (idx_inc == len_q) begin
                        words_done_d = idx_inc;
                        done_d       = 1'b1;
                        hold_d       = HOLD_W'(RST_HOLD - 1);
                        state_d      = ST_HOLD;
                    end else begin
                        idx_d   = idx_inc;
                        state_d = ST_DUMP_RD;
                    end
                end
            end
`ifdef BRAM_LOAD_VERIFY_EN
            ST_VERIFY: begin
                // Reads are pipelined: issue idx while folding in the previous read.
                if (idx_q != words_done_q) begin
                    bram_a2 = idx_addr;
                    idx_d   = idx_inc;
                    pend_d  = 1'b1;
                end
                if (pend_q) begin
                    vacc_d = vacc_q ^ rd_sel;
                    vcnt_d = vcnt_q + LEN_W'(1);
                end
                if (pend_q && idx_q == words_done_q) begin
                    verify_err_d = (vacc_d != shadow_q) || (vcnt_d != words_done_q);
                    done_d       = 1'b1;
                    hold_d       = HOLD_W'(RST_HOLD - 1);
                    state_d      = ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (hold_q == '0) begin
                    core_rst_d = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers; CPU_RST aborts any op in flight.
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            len_q        <= '0;
            chan_q       <= '0;
            hold_q       <= '0;
            core_rst_q   <= 1'b0;
            done_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            first_q      <= 1'b0;
            words_done_q <= '0;
            out_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            chan_q       <= chan_d;
            hold_q       <= hold_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            cmd_err_q    <= cmd_err_d;
            first_q      <= first_d;
            words_done_q <= words_done_d;
            out_data_q   <= out_data_d;
        end
    end

`ifdef BRAM_LOAD_VERIFY_EN
    // Load read-back checksum registers.
    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            shadow_q     <= '0;
            vacc_q       <= '0;
            vcnt_q       <= '0;
            pend_q       <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            vacc_q       <= vacc_d;
            vcnt_q       <= vcnt_d;
            pend_q       <= pend_d;
            verify_err_q <= verify_err_d;
        end
    end

    assign verify_err = verify_err_q;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign cmd_err    = cmd_err_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// Directed bench for bram_debug_sequencer with a two-channel BRAM model
// (registered read, one-cycle latency).
module tb_bram_debug_sequencer;

    logic        clk = 1'b0;
    logic        CPU_RST, cmd_valid, cmd_ready, cmd_op;
    logic [1:0]  cmd_chan;
    logic [12:0] cmd_len;
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data, out_addr;
    logic [63:0] dbg_a2, dbg_wd2, dbg_rd2;
    logic [7:0]  dbg_we2;
    logic        core_rst, busy, done, cmd_err;
    logic [12:0] words_done;
`ifdef BRAM_LOAD_VERIFY_EN
    logic        verify_err;
`endif

    logic        bram_init, corrupt;
    logic [31:0] mem [2][64];
    int          wr_cnt [2];
    int          done_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    bram_debug_sequencer #(
        .CHANNELS (2), .WORDS (4096), .DATA_W (32), .ADDR_W (32), .RST_HOLD (4)
    ) dut (
        .CPU_CLK (clk), .CPU_RST (CPU_RST),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_op (cmd_op),
        .cmd_chan (cmd_chan), .cmd_len (cmd_len),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_last (in_last),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data),
        .out_addr (out_addr), .out_last (out_last),
        .dbg_a2 (dbg_a2), .dbg_wd2 (dbg_wd2), .dbg_we2 (dbg_we2), .dbg_rd2 (dbg_rd2),
        .core_rst (core_rst), .busy (busy), .done (done), .cmd_err (cmd_err),
        .words_done (words_done)
`ifdef BRAM_LOAD_VERIFY_EN
        , .verify_err (verify_err)
`endif
    );

    function automatic logic [31:0] pat(input int c, input int i);
        return 32'h5000_0000 | (32'(c) << 12) | 32'(i);
    endfunction

    // BRAM model: byte-enable write, registered read, optional corruption of ch1 addr 4.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (bram_init) begin
                for (int i = 0; i < 64; i++) mem[c][i] <= pat(c, i);
                wr_cnt[c] <= 0;
            end else if (dbg_we2[c*4 +: 4] != 4'h0) begin
                mem[c][dbg_a2[c*32+2 +: 6]] <= dbg_wd2[c*32 +: 32];
                wr_cnt[c] <= wr_cnt[c] + 1;
            end
            dbg_rd2[c*32 +: 32] <= mem[c][dbg_a2[c*32+2 +: 6]] ^
                (((corrupt && c == 1) && (dbg_a2[c*32 +: 32] == 32'd4)) ? 32'hDEAD_BEEF : 32'h0);
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic op, input logic [1:0] ch, input logic [12:0] len);
        cmd_valid = 1'b1; cmd_op = op; cmd_chan = ch; cmd_len = len;
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        check(tag, done, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hs, bad;
        logic [31:0] dexp [3];
        logic [31:0] aexp;
        dexp[0] = 32'h11; dexp[1] = 32'h22; dexp[2] = 32'h33;
        CPU_RST = 1'b1; bram_init = 1'b1; corrupt = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_chan = 2'd0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        step(3);

        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_core_rst", core_rst, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cmd_err", cmd_err, 1'b0);
        check("rst_dbg_a2", dbg_a2, 64'h0);
        check("rst_dbg_we2", dbg_we2, 8'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        CPU_RST = 1'b0; bram_init = 1'b0;
        step(1);

        // Load ch1, three words.
        issue(1'b0, 2'd1, 13'd3);
        check("ld_busy", busy, 1'b1);
        check("ld_core_rst", core_rst, 1'b1);
        check("ld_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = dexp[k];
            #1;
            check("ld_we2", dbg_we2, 8'hF0);
            check("ld_a2", dbg_a2, {32'(k * 4), 32'h0});
            check("ld_wd2", dbg_wd2, {dexp[k], 32'h0});
            step(1);
        end
        in_valid = 1'b0;
        wait_done("ld_done");
        check("ld_words_done", words_done, 13'd3);
        check("ld_mem0", mem[1][0], 32'h11);
        check("ld_mem1", mem[1][1], 32'h22);
        check("ld_mem2", mem[1][2], 32'h33);
        check("ld_mem3_untouched", mem[1][3], pat(1, 3));
        check("ld_ch0_writes", wr_cnt[0], 0);
        check("ld_ch1_writes", wr_cnt[1], 3);
        step(6);
        check("ld_idle", cmd_ready, 1'b1);

        // Dump ch1 with out_ready high one cycle in three.
        issue(1'b1, 2'd1, 13'd3);
        hs = 0; cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            out_ready = (cyc % 3 == 2);
            #1;
            if (out_valid === 1'b1) begin
                if (hs < 3) begin
                    check("dp_data", out_data, dexp[hs]);
                    check("dp_addr", out_addr, 32'(hs * 4));
                    check("dp_last", out_last, (hs == 2));
                end else begin
                    check("dp_extra_word", hs, 2);
                end
                if (out_ready) hs++;
            end
            step(1);
            cyc++;
        end
        out_ready = 1'b0;
        check("dp_count", hs, 3);
        check("dp_done", done, 1'b1);
        check("dp_words_done", words_done, 13'd3);
        check("dp_no_writes", wr_cnt[1], 3);
        step(6);

        // Load ch0 len 5, in_last on the second beat.
        issue(1'b0, 2'd0, 13'd5);
        in_valid = 1'b1; in_data = 32'hA1; in_last = 1'b0;
        step(1);
        in_data = 32'hA2; in_last = 1'b1;
        step(1);
        in_data = 32'hBAD; in_last = 1'b0;
        check("l4_in_ready_after_last", in_ready, 1'b0);
        wait_done("l4_done");
        in_valid = 1'b0;
        check("l4_words_done", words_done, 13'd2);
        check("l4_core_rst_at_done", core_rst, 1'b1);
        step(3);
        check("l4_core_rst_hold", core_rst, 1'b1);
        step(1);
        check("l4_core_rst_release", core_rst, 1'b0);
        check("l4_cmd_ready", cmd_ready, 1'b1);
        check("l4_mem0", mem[0][0], 32'hA1);
        check("l4_mem1", mem[0][1], 32'hA2);
        check("l4_mem2_untouched", mem[0][2], pat(0, 2));
        check("l4_writes", wr_cnt[0], 2);

        // Out-of-range channel.
        in_valid = 1'b1; in_data = 32'hFEED;
        issue(1'b0, 2'd2, 13'd3);
        check("bad_cmd_err", cmd_err, 1'b1);
        check("bad_busy", busy, 1'b0);
        check("bad_cmd_ready", cmd_ready, 1'b1);
        check("bad_we2", dbg_we2, 8'h0);
        step(1);
        in_valid = 1'b0;
        check("bad_cmd_err_pulse", cmd_err, 1'b0);
        check("bad_no_writes", wr_cnt[0] + wr_cnt[1], 5);

        // Zero-length command.
        issue(1'b0, 2'd0, 13'd0);
        check("len0_done", done, 1'b1);
        check("len0_words_done", words_done, 13'd0);
        check("len0_busy", busy, 1'b0);
        check("len0_core_rst", core_rst, 1'b0);
        step(1);
        check("len0_done_pulse", done, 1'b0);
        check("len0_no_writes", wr_cnt[0] + wr_cnt[1], 5);

        // Dump ch0 len 20, abort at word 10.
        issue(1'b1, 2'd0, 13'd20);
        out_ready = 1'b1;
        hs = 0; cyc = 0; bad = 0;
        while (hs < 10 && cyc < 100) begin
            if (out_valid === 1'b1) begin
                aexp = (hs == 0) ? 32'hA1 : (hs == 1) ? 32'hA2 : pat(0, hs);
                if (out_data !== aexp) bad++;
                if (out_addr !== 32'(hs * 4)) bad++;
                hs++;
            end
            step(1);
            cyc++;
        end
        check("ab_words_before_abort", hs, 10);
        check("ab_stream_errors", bad, 0);
        check("ab_busy_before", busy, 1'b1);
        CPU_RST = 1'b1;
        step(1);
        check("ab_cmd_ready", cmd_ready, 1'b1);
        check("ab_busy", busy, 1'b0);
        check("ab_core_rst", core_rst, 1'b0);
        check("ab_out_valid", out_valid, 1'b0);
        check("ab_out_data", out_data, 32'h0);
        check("ab_dbg_a2", dbg_a2, 64'h0);
        check("ab_dbg_we2", dbg_we2, 8'h0);
        check("ab_done", done, 1'b0);
        check("ab_words_done", words_done, 13'd0);
        CPU_RST = 1'b0; out_ready = 1'b0;
        step(3);
        check("ab_done_count", done_cnt, 4);

`ifdef BRAM_LOAD_VERIFY_EN
        // Read-back verify with corrupted and clean read data.
        corrupt = 1'b1;
        issue(1'b0, 2'd1, 13'd3);
        check("vf_err_clear_on_accept", verify_err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 32'(k + 1);
            step(1);
        end
        in_valid = 1'b0;
        wait_done("vf_bad_done");
        check("vf_bad_err", verify_err, 1'b1);
        step(6);
        check("vf_bad_err_held", verify_err, 1'b1);
        corrupt = 1'b0;
        issue(1'b0, 2'd1, 13'd3);
        check("vf_err_cleared", verify_err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 32'(k + 1);
            step(1);
        end
        in_valid = 1'b0;
        wait_done("vf_good_done");
        check("vf_good_err", verify_err, 1'b0);
        step(6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
